// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ requesters
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W_WIDTH   = 32,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    localparam int IW = $clog2(N_REQ),
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W_WIDTH-1:0] din_bus,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [IW-1:0]            grant_id,
    output logic                     busy,
    output logic                     fifo_wr_en,
    output logic [W_WIDTH-1:0]       fifo_din,
    input  logic                     fifo_wfull,
    input  logic [CW-1:0]            fifo_cnt
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic [BW-1:0] cnt;
    logic [CW-1:0] free;
    logic          beat;
    logic          room;
    logic          burst_end;
    assign free      = CW'(DEPTH) - fifo_cnt;
    assign room      = free >= CW'(BURST_LEN);
    assign beat      = (state == GRANT) && req[grant_id] && !fifo_wfull;
    assign burst_end = !req[grant_id] || (beat && cnt == BW'(BURST_LEN - 1));
    assign ack       = beat ? (N_REQ'(1) << grant_id) : '0;
    assign fifo_wr_en = beat;
    assign fifo_din  = din_bus[grant_id*W_WIDTH +: W_WIDTH];
    // scan downward so the last hit is the first requester after the rotation pointer
    always_comb begin
        win = last;
        idx = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N_REQ);
            if (req[idx]) win = idx;
        end
    end
    // two-state burst FSM with registered grant outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            last     <= IW'(N_REQ - 1);
            cnt      <= '0;
        end else if (state == IDLE) begin
            if (|req && room) begin
                state    <= GRANT;
                gnt      <= N_REQ'(1) << win;
                grant_id <= win;
                busy     <= 1'b1;
                cnt      <= '0;
            end else begin
                gnt <= '0;
            end
        end else if (burst_end) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            last  <= grant_id;
        end else if (beat) begin
            cnt <= cnt + BW'(1);
        end
    end
endmodule
